// File: rtl/pbit_gibbs_sweeper.sv
// Sequential Gibbs-sampling p-bit engine: updates one node per cycle against a
// Galois LFSR, with per-bit clamping and a programmable number of sweeps.

module pbit_gibbs_sweeper_chk (
    input logic        clk,
    input logic        rst,
    input logic        busy,
    input logic        done,
    input logic [15:0] lfsr
);

    a_busy_done_excl: assert property (@(posedge clk) disable iff (rst) !(busy && done));
    a_lfsr_nonzero:   assert property (@(posedge clk) disable iff (rst) lfsr != 16'h0000);
    a_done_single:    assert property (@(posedge clk) disable iff (rst) done |=> !done);

endmodule

module pbit_gibbs_sweeper #(
    parameter int          N_PBITS   = 5,
    parameter int          ACT_W     = 4,
    parameter int          RAND_W    = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [7:0]                 num_sweeps,
    input  logic [1:0]                 beta_shift,
    input  logic [N_PBITS*ACT_W-1:0]   act_in,
    input  logic [N_PBITS-1:0]         clamp_en,
    input  logic [N_PBITS-1:0]         clamp_val,
    output logic [N_PBITS-1:0]         state_out,
    output logic                       busy,
    output logic                       done,
    output logic [7:0]                 sweep_count
);

    localparam int IDX_W = (N_PBITS > 1) ? $clog2(N_PBITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PBITS - 1);
    localparam int EXT_W = RAND_W + 4;
    localparam int SUM_W = RAND_W + 2;
    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] TOGGLE_MASK = 16'hB400;
    localparam logic signed [EXT_W-1:0] SAT_POS = EXT_W'(2 ** (RAND_W - 1));
    localparam logic signed [EXT_W-1:0] SAT_NEG = -SAT_POS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        FINISH = 2'd2
    } fsm_t;

    fsm_t                 fsm_r;
    logic [IDX_W-1:0]     idx_r;
    logic [15:0]          lfsr_r;
    logic [7:0]           num_sweeps_r;
    logic [1:0]           beta_shift_r;
    logic [N_PBITS-1:0]   state_r;
    logic                 busy_r;
    logic                 done_r;
    logic [7:0]           sweep_count_r;

    logic [ACT_W-1:0]         act_sel_s;
    logic signed [EXT_W-1:0]  act_ext_s;
    logic signed [EXT_W-1:0]  act_shift_s;
    logic [2:0]               shamt_s;
    logic [SUM_W-1:0]         scaled_s;
    logic [SUM_W-1:0]         rand_s;
    logic [SUM_W-1:0]         sum_s;
    logic                     sample_s;
    logic                     next_bit_s;
    logic [7:0]               sweep_next_s;

    // Right-shifting Galois step; a nonzero state can never map to zero.
    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        logic [15:0] nxt;
        if (x[0]) begin
            nxt = (x >> 1) ^ TOGGLE_MASK;
        end else begin
            nxt = x >> 1;
        end
        return nxt;
    endfunction

    // Scaled, saturated activation of the selected node compared against the LFSR sample.
    always_comb begin
        act_sel_s   = act_in[int'(idx_r) * ACT_W +: ACT_W];
        act_ext_s   = {{(EXT_W - ACT_W){act_sel_s[ACT_W-1]}}, act_sel_s};
        shamt_s     = {1'b0, beta_shift_r} + 3'd3;
        act_shift_s = act_ext_s <<< shamt_s;
        if (act_shift_s > SAT_POS) begin
            scaled_s = SAT_POS[SUM_W-1:0];
        end else if (act_shift_s < SAT_NEG) begin
            scaled_s = SAT_NEG[SUM_W-1:0];
        end else begin
            scaled_s = act_shift_s[SUM_W-1:0];
        end
        rand_s   = {{(SUM_W - RAND_W){lfsr_r[RAND_W-1]}}, lfsr_r[RAND_W-1:0]};
        sum_s    = rand_s + scaled_s;
        sample_s = ~sum_s[SUM_W-1];
        if (clamp_en[idx_r]) begin
            next_bit_s = clamp_val[idx_r];
        end else begin
            next_bit_s = sample_s;
        end
        sweep_next_s = sweep_count_r + 8'd1;
    end

    // Sweep controller, node-state register and LFSR.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_r         <= IDLE;
            idx_r         <= '0;
            lfsr_r        <= SEED_EFF;
            num_sweeps_r  <= 8'd0;
            beta_shift_r  <= 2'd0;
            state_r       <= '0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            sweep_count_r <= 8'd0;
        end else begin
            case (fsm_r)
                IDLE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    if (start) begin
                        num_sweeps_r  <= num_sweeps;
                        beta_shift_r  <= beta_shift;
                        sweep_count_r <= 8'd0;
                        idx_r         <= '0;
                        if (num_sweeps == 8'd0) begin
                            fsm_r  <= FINISH;
                            done_r <= 1'b1;
                        end else begin
                            fsm_r  <= UPDATE;
                            busy_r <= 1'b1;
                        end
                    end else begin
                        fsm_r <= IDLE;
                    end
                end
                UPDATE: begin
                    state_r[idx_r] <= next_bit_s;
                    lfsr_r         <= lfsr_step(lfsr_r);
                    if (idx_r == LAST_IDX) begin
                        idx_r         <= '0;
                        sweep_count_r <= sweep_next_s;
                        if (sweep_next_s == num_sweeps_r) begin
                            fsm_r  <= FINISH;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end else begin
                            fsm_r <= UPDATE;
                        end
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                FINISH: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    fsm_r  <= IDLE;
                end
                default: begin
                    fsm_r  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign state_out   = state_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign sweep_count = sweep_count_r;

    pbit_gibbs_sweeper_chk u_chk (
        .clk  (clk),
        .rst  (rst),
        .busy (busy_r),
        .done (done_r),
        .lfsr (lfsr_r)
    );

endmodule

// File: tb/tb_pbit_gibbs_sweeper.sv
// Directed-vector bench for pbit_gibbs_sweeper: saturated activations give
// deterministic states; a zero-activation run is checked against an LFSR model.

module tb_pbit_gibbs_sweeper;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  num_sweeps;
    logic [1:0]  beta_shift;
    logic [19:0] act_in;
    logic [4:0]  clamp_en;
    logic [4:0]  clamp_val;
    logic [4:0]  state_out;
    logic        busy;
    logic        done;
    logic [7:0]  sweep_count;

    int tests = 0;
    int fails = 0;
    logic [15:0]  lfsr_m;
    logic [199:0] n0_bits;
    logic [199:0] first_bits;

    typedef struct {
        logic [19:0] act;
        logic [1:0]  beta;
        logic [7:0]  ns;
        logic [4:0]  ce;
        logic [4:0]  cv;
        logic [4:0]  exp_state;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    pbit_gibbs_sweeper dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_sweeps  (num_sweeps),
        .beta_shift  (beta_shift),
        .act_in      (act_in),
        .clamp_en    (clamp_en),
        .clamp_val   (clamp_val),
        .state_out   (state_out),
        .busy        (busy),
        .done        (done),
        .sweep_count (sweep_count)
    );

    function automatic logic [15:0] lfsr_adv(input logic [15:0] x, input int n);
        logic [15:0] v;
        v = x;
        for (int k = 0; k < n; k++) begin
            v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Starts a run and watches it until two cycles past done (bounded).
    task automatic run(input logic [7:0] ns, input logic [1:0] beta, input int inj_cycle,
                       output int done_cyc, output int busy_cyc, output int done_cnt);
        @(negedge clk);
        num_sweeps = ns;
        beta_shift = beta;
        start      = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        done_cyc = -1;
        busy_cyc = 0;
        done_cnt = 0;
        n0_bits  = '0;
        for (int c = 1; c <= 1500; c++) begin
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (c >= 2 && ((c - 2) % 5) == 0 && ((c - 2) / 5) < 200) begin
                n0_bits[(c - 2) / 5] = state_out[0];
            end
            if (inj_cycle > 0 && c == inj_cycle) begin
                start      = 1'b1;
                num_sweeps = 8'd9;
            end else if (inj_cycle > 0 && c == inj_cycle + 1) begin
                start = 1'b0;
            end
            if (done_cyc > 0 && c >= done_cyc + 2) break;
            @(negedge clk);
        end
    endtask

    initial begin
        int dc, bc, dn, ones_dut, ones_m, mism;
        logic [15:0] m;
        logic [4:0] prev_state;

        rst = 1'b1; start = 1'b0; num_sweeps = 8'd0; beta_shift = 2'd0;
        act_in = 20'h00000; clamp_en = 5'b00000; clamp_val = 5'b00000;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state_out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_sweep_count", 32'(sweep_count), 32'h0);
        check("rst_lfsr", 32'(dut.lfsr_r), 32'(SEED));
        rst = 1'b0;
        lfsr_m = SEED;

        vecs[0] = '{20'h77777, 2'd3, 8'd1, 5'b00000, 5'b00000, 5'b11111};
        vecs[1] = '{20'h88888, 2'd3, 8'd2, 5'b00000, 5'b00000, 5'b00000};
        vecs[2] = '{20'h77777, 2'd3, 8'd1, 5'b11000, 5'b10000, 5'b10111};
        vecs[3] = '{20'hCCCCC, 2'd2, 8'd3, 5'b00101, 5'b00001, 5'b00001};
        vecs[4] = '{20'h22222, 2'd3, 8'd1, 5'b00010, 5'b00000, 5'b11101};
        vecs[5] = '{20'hEEEEE, 2'd3, 8'd1, 5'b00000, 5'b00000, 5'b00000};
        vecs[6] = '{20'h44444, 2'd2, 8'd1, 5'b11111, 5'b01010, 5'b01010};
        vecs[7] = '{20'h2C487, 2'd3, 8'd1, 5'b00000, 5'b00000, 5'b10101};

        for (int i = 0; i < 8; i++) begin
            act_in    = vecs[i].act;
            clamp_en  = vecs[i].ce;
            clamp_val = vecs[i].cv;
            run(vecs[i].ns, vecs[i].beta, 0, dc, bc, dn);
            lfsr_m = lfsr_adv(lfsr_m, int'(vecs[i].ns) * 5);
            check($sformatf("v%0d_state", i), 32'(state_out), 32'(vecs[i].exp_state));
            check($sformatf("v%0d_sweep_count", i), 32'(sweep_count), 32'(vecs[i].ns));
            check($sformatf("v%0d_done_cycle", i), 32'(dc), 32'(int'(vecs[i].ns) * 5 + 1));
            check($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(int'(vecs[i].ns) * 5));
            check($sformatf("v%0d_done_pulses", i), 32'(dn), 32'd1);
            check($sformatf("v%0d_lfsr", i), 32'(dut.lfsr_r), 32'(lfsr_m));
        end

        // Zero sweeps: immediate done, nothing moves.
        prev_state = 5'b10101;
        clamp_en = 5'b00000; clamp_val = 5'b00000; act_in = 20'h88888;
        run(8'd0, 2'd3, 0, dc, bc, dn);
        check("zero_done_cycle", 32'(dc), 32'd1);
        check("zero_busy_cycles", 32'(bc), 32'd0);
        check("zero_state", 32'(state_out), 32'(prev_state));
        check("zero_lfsr", 32'(dut.lfsr_r), 32'(lfsr_m));

        // Start while busy is ignored.
        act_in = 20'h77777;
        run(8'd4, 2'd3, 3, dc, bc, dn);
        lfsr_m = lfsr_adv(lfsr_m, 20);
        check("ign_done_cycle", 32'(dc), 32'd21);
        check("ign_busy_cycles", 32'(bc), 32'd20);
        check("ign_sweep_count", 32'(sweep_count), 32'd4);
        check("ign_done_pulses", 32'(dn), 32'd1);
        check("ign_state", 32'(state_out), 32'h1F);
        check("ign_lfsr", 32'(dut.lfsr_r), 32'(lfsr_m));

        // Reset in cycle 7 of a run aborts it without a done pulse.
        act_in = 20'h88888;
        @(negedge clk);
        num_sweeps = 8'd4; beta_shift = 2'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_state", 32'(state_out), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        check("abort_sweep_count", 32'(sweep_count), 32'h0);
        check("abort_lfsr", 32'(dut.lfsr_r), 32'(SEED));
        dn = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("abort_no_done", 32'(dn), 32'd0);

        // Start together with reset is ignored.
        act_in = 20'h77777;
        rst = 1'b1; start = 1'b1; num_sweeps = 8'd1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        bc = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (busy || done) bc++;
        end
        check("rst_start_idle", 32'(bc), 32'd0);
        check("rst_start_state", 32'(state_out), 32'h0);
        lfsr_m = SEED;

        // Unbiased sampling on node 0 against the LFSR model, twice from the seed.
        act_in = 20'h00000;
        for (int pass = 0; pass < 2; pass++) begin
            run(8'd200, 2'd0, 0, dc, bc, dn);
            check($sformatf("s0_p%0d_done_cycle", pass), 32'(dc), 32'd1001);
            ones_dut = 0; ones_m = 0; mism = 0;
            for (int k = 0; k < 200; k++) begin
                m = lfsr_adv(SEED, 5 * k);
                if (!m[7]) ones_m++;
                if (n0_bits[k]) ones_dut++;
                if (n0_bits[k] !== ~m[7]) mism++;
            end
            check($sformatf("s0_p%0d_seq_mismatches", pass), 32'(mism), 32'd0);
            check($sformatf("s0_p%0d_ones", pass), 32'(ones_dut), 32'(ones_m));
            check($sformatf("s0_p%0d_ones_in_range", pass),
                  32'((ones_dut >= 80) && (ones_dut <= 120)), 32'd1);
            if (pass == 0) begin
                first_bits = n0_bits;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                mism = 0;
                for (int k = 0; k < 200; k++) begin
                    if (n0_bits[k] !== first_bits[k]) mism++;
                end
                check("s0_rerun_identical", 32'(mism), 32'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pbit_gibbs_sweeper.md
Name: pbit_gibbs_sweeper

Overview:
- Sequential p-bit update engine sitting directly downstream of the hard-coded gate activation networks (COPY/NOT/AND/OR/HA/FA).
- Consumes their 4-bit signed per-node activations, samples each p-bit in turn against an internal LFSR (sequential Gibbs sampling), and registers the node states.
- Those states feed back as the gates' `in` vector.
- Supports per-bit clamping for inverted/constrained operation and runs a programmed number of full sweeps per start.

Parameters:
- N_PBITS, 5, number of p-bits/nodes handled (matches widest gate, the FA).
- ACT_W, 4, width of each signed activation input.
- RAND_W, 8, width of the random sample compared against the scaled activation.
- LFSR_SEED, 16'hACE1, reset value of the 16-bit LFSR; a value of 0 is replaced by 16'h0001.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a run when idle
- num_sweeps  in  8  number of full sweeps per run, sampled on accepted start
- beta_shift  in  2  inverse-temperature; scale = 2^(beta_shift+3), sampled on accepted start
- act_in  in  N_PBITS*ACT_W  flattened signed activations; node i at [i*ACT_W +: ACT_W]; combinational function of state_out
- clamp_en  in  N_PBITS  per-bit clamp enable, sampled live each update cycle
- clamp_val  in  N_PBITS  clamp value for clamped bits
- state_out  out  N_PBITS  registered p-bit states (1 = +1, 0 = -1)
- busy  out  1  high while sweeping
- done  out  1  one-cycle pulse at end of run
- sweep_count  out  8  completed sweeps in the current or last run

Behaviour:
- Reset values (synchronous, on rst=1 at clk edge, overrides everything):
  - state_out=0, busy=0, done=0, sweep_count=0
  - idx=0, FSM=IDLE, lfsr=LFSR_SEED (or 1 if the seed is 0)
- Reset mid-run aborts the run; no done pulse is issued.
- FSM states: IDLE, UPDATE, FINISH.
- IDLE:
  - start=1 latches num_sweeps and beta_shift, clears sweep_count and idx.
  - num_sweeps=0 goes to FINISH; otherwise goes to UPDATE.
- UPDATE:
  - One p-bit per cycle, idx = 0..N_PBITS-1 ascending.
  - busy=1 from the cycle after accepted start through the last update cycle.
  - Each cycle for node i = idx:
    - a = sign-extended act_in slice.
    - s = a <<< (beta_shift+3), computed in RAND_W+4 bits, saturated to [-2^(RAND_W-1), +2^(RAND_W-1)], i.e. [-128, +128].
    - r = signed(lfsr[RAND_W-1:0]).
    - Next state_out[i] = clamp_en[i] ? clamp_val[i] : ((r + s) >= 0), evaluated in RAND_W+2 signed bits.
    - Only bit i changes; the other bits hold.
  - At idx=N_PBITS-1: idx wraps to 0 and sweep_count increments. If the new sweep_count equals the latched num_sweeps, go to FINISH.
- FINISH: done=1 for exactly one cycle, busy=0, go to IDLE.
- Update latency: a new state is visible on state_out one cycle after its update cycle. Node i+1 therefore sees activations computed from the already-updated node i, which is required for Gibbs correctness.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (toggle mask 16'hB400), shift right.
  - Advances once per UPDATE cycle only, including clamped cycles; holds in IDLE and FINISH.
  - Never reaches 0.
- start while busy or during FINISH is ignored; the latched num_sweeps and beta_shift are unaffected.
- start in the same cycle as rst is ignored.
- Extremes:
  - s=+128 always yields 1.
  - s=-128 always yields 0.
  - s=0 yields 1 with probability 128/256.
- Total run length: num_sweeps*N_PBITS update cycles, plus 1 FINISH cycle.
- state_out holds its value in IDLE; a new run continues from the current state, not from zero.

Test Plan:
1. Reset, then act_in all +7, beta_shift=3, num_sweeps=1, no clamps, start -> state_out=5'b11111 after 5 update cycles; done pulses on cycle 6 after start; sweep_count=1.
2. act_in all -8, beta_shift=3, num_sweeps=2 from state 5'b11111 -> state_out=5'b00000; busy high exactly 10 cycles; sweep_count=2.
3. clamp_en=5'b11000, clamp_val=5'b10000, act_in all +7, beta_shift=3 -> state_out=5'b10111; LFSR state after the run equals the seed stepped 5 times.
4. num_sweeps=0, start -> busy never rises; done pulses the cycle after start; state_out and LFSR unchanged.
5. During a num_sweeps=4 run, pulse start at cycle 3 with num_sweeps=9 -> ignored, run ends after 20 update cycles. Assert rst at cycle 7 of a new run -> all outputs at reset values next cycle, no done pulse.
6. Single node, act_in=0, beta_shift=0, num_sweeps=200, N_PBITS=5 (node 0 observed) -> count of ones on node 0 over 200 sweeps within 80..120; identical sequence on rerun with the same seed.
